// File: rtl/plic_pkg.sv
// PLIC core shared definitions: register word map, gateway states, limits.
// Edge-trigger support is compiled in only when PLIC_EDGE_EN is defined.
package plic_pkg;

    localparam int MAX_SRC = 32;
    localparam int ID_W    = 5;

    localparam logic [7:0] ADDR_IP    = 8'h20;
    localparam logic [7:0] ADDR_IE    = 8'h21;
    localparam logic [7:0] ADDR_THOLD = 8'h22;
    localparam logic [7:0] ADDR_CLAIM = 8'h23;
    localparam logic [7:0] ADDR_MODE  = 8'h24;

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PEND     = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_e;

endpackage

// File: rtl/plic_if.sv
// Single-cycle, always-ready register port of the PLIC core.
// Master drives the access, slave returns read data combinationally.
interface plic_if;
    logic        reg_we_i;
    logic        reg_re_i;
    logic [7:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;

    modport master (
        output reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
        input  reg_rdata_o
    );

    modport slave (
        input  reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
        output reg_rdata_o
    );
endinterface

// File: rtl/plic_gateway.sv
// Per-source gateway: IDLE -> PEND -> INFLIGHT -> IDLE.
// Rising-edge trigger mode exists only when PLIC_EDGE_EN is defined.
module plic_gateway
    import plic_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef PLIC_EDGE_EN
    input  logic edge_mode,
`endif
    input  logic irq,
    input  logic claim,
    input  logic complete,
    output logic pend
);

    gw_state_e state, state_n;
    logic      req;
    logic      drop;

`ifdef PLIC_EDGE_EN
    logic irq_q;

    // edge-detect history, updated every cycle regardless of state
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq;
    end

    assign req  = edge_mode ? (irq & ~irq_q) : irq;
    assign drop = ~edge_mode & ~irq;
`else
    assign req  = irq;
    assign drop = ~irq;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= GW_IDLE;
        else     state <= state_n;
    end

    // next state: claim beats a same-cycle request, requests ignored in flight
    always_comb begin
        state_n = state;
        unique case (state)
            GW_IDLE:     if (req) state_n = GW_PEND;
            GW_PEND: begin
                if (claim)     state_n = GW_INFLIGHT;
                else if (drop) state_n = GW_IDLE;
            end
            GW_INFLIGHT: if (complete) state_n = GW_IDLE;
            default:     state_n = GW_IDLE;
        endcase
    end

    // pending flag feeds the IP register
    always_comb begin
        pend = (state == GW_PEND);
    end

endmodule

// File: rtl/plic_core.sv
// Single-target PLIC: priorities, enables, threshold, claim/complete.
// Define PLIC_EDGE_EN to add the MODE register and edge-triggered sources.
module plic_core
    import plic_pkg::*;
#(
    parameter int IRQ_NUM    = 8,
    parameter int PRIO_WIDTH = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    plic_if.slave              bus,
    output logic               ext_irq_o
);

    logic [PRIO_WIDTH-1:0] prio [IRQ_NUM];
    logic [IRQ_NUM-1:0]    ie;
    logic [PRIO_WIDTH-1:0] thold;
    logic [IRQ_NUM-1:0]    ip;
    logic [IRQ_NUM-1:0]    elig;
    logic [ID_W-1:0]       winner;
    logic [PRIO_WIDTH-1:0] best_p;
    logic                  claim_rd;
    logic                  comp_wr;
    logic                  unused_bits;

`ifdef PLIC_EDGE_EN
    logic [IRQ_NUM-1:0]    mode;
`endif

    assign claim_rd = bus.reg_re_i && (bus.reg_addr_i == ADDR_CLAIM);
    assign comp_wr  = bus.reg_we_i && (bus.reg_addr_i == ADDR_CLAIM);
    assign unused_bits = ^{irq_i[0], bus.reg_wdata_i};

    // configuration registers; PRIO[0] stays zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < IRQ_NUM; i++) prio[i] <= '0;
            ie    <= '0;
            thold <= '0;
`ifdef PLIC_EDGE_EN
            mode  <= '0;
`endif
        end else if (bus.reg_we_i) begin
            for (int i = 1; i < IRQ_NUM; i++) begin
                if (bus.reg_addr_i == 8'(i))
                    prio[i] <= bus.reg_wdata_i[PRIO_WIDTH-1:0];
            end
            if (bus.reg_addr_i == ADDR_IE)
                ie <= bus.reg_wdata_i[IRQ_NUM-1:0];
            if (bus.reg_addr_i == ADDR_THOLD)
                thold <= bus.reg_wdata_i[PRIO_WIDTH-1:0];
`ifdef PLIC_EDGE_EN
            if (bus.reg_addr_i == ADDR_MODE)
                mode <= bus.reg_wdata_i[IRQ_NUM-1:0]
                      & {{(IRQ_NUM-1){1'b1}}, 1'b0};
`endif
        end
    end

    assign ip[0] = 1'b0;

    for (genvar g = 1; g < IRQ_NUM; g++) begin : g_gw
        plic_gateway u_gw (
            .clk       (clk_i),
            .rst       (rst_i),
`ifdef PLIC_EDGE_EN
            .edge_mode (mode[g]),
`endif
            .irq       (irq_i[g]),
            .claim     (claim_rd && (winner == ID_W'(g))),
            .complete  (comp_wr && (bus.reg_wdata_i[ID_W-1:0] == ID_W'(g))),
            .pend      (ip[g])
        );
    end

    // arbitration: highest priority above threshold, ties to lowest ID
    always_comb begin
        elig   = '0;
        winner = '0;
        best_p = '0;
        for (int i = 1; i < IRQ_NUM; i++) begin
            elig[i] = ip[i] & ie[i] & (prio[i] > thold);
            if (elig[i] && (prio[i] > best_p)) begin
                winner = ID_W'(i);
                best_p = prio[i];
            end
        end
    end

    // target request, registered one cycle behind the arbiter
    always_ff @(posedge clk_i) begin
        if (rst_i) ext_irq_o <= 1'b0;
        else       ext_irq_o <= (winner != '0);
    end

    // read mux, zero when no read is in progress
    always_comb begin
        bus.reg_rdata_o = '0;
        if (bus.reg_re_i) begin
            case (bus.reg_addr_i)
                ADDR_IP:    bus.reg_rdata_o[IRQ_NUM-1:0]    = ip;
                ADDR_IE:    bus.reg_rdata_o[IRQ_NUM-1:0]    = ie;
                ADDR_THOLD: bus.reg_rdata_o[PRIO_WIDTH-1:0] = thold;
                ADDR_CLAIM: bus.reg_rdata_o[ID_W-1:0]       = winner;
`ifdef PLIC_EDGE_EN
                ADDR_MODE:  bus.reg_rdata_o[IRQ_NUM-1:0]    = mode;
`endif
                default: begin
                    for (int i = 1; i < IRQ_NUM; i++) begin
                        if (bus.reg_addr_i == 8'(i))
                            bus.reg_rdata_o[PRIO_WIDTH-1:0] = prio[i];
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/plic_core.md
PLIC_CORE -- requirements
Module: plic_core

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 8, meaning source count including tied-off source 0 (range 2..32).
REQ-002 SHALL have parameter PRIO_WIDTH, default 3, meaning priority and threshold width (1..8).
REQ-003 SHALL have ports clk_i in 1 (clock) and rst_i in 1 (reset); one clock, synchronous active-high reset.
REQ-004 SHALL have irq_i in IRQ_NUM, meaning raw sources; bit 0 ignored and treated as 0.
REQ-005 SHALL have reg_we_i in 1, reg_re_i in 1, reg_addr_i in 8 (word index), reg_wdata_i in 32, reg_rdata_o out 32: single-cycle register port, always ready.
REQ-006 SHALL have ext_irq_o out 1, meaning target interrupt request.

Function
REQ-007 SHALL map words: 0..IRQ_NUM-1 PRIO[i] RW (PRIO[0] reads 0, writes ignored); 0x20 IP RO; 0x21 IE RW; 0x22 THOLD RW; 0x23 CLAIMCOMP; 0x24 MODE RW (PLIC_EDGE_EN only); others read 0, writes ignored.
REQ-008 SHALL drive reg_rdata_o combinationally during reg_re_i, else 0; unused upper bits 0.
REQ-009 SHALL have one gateway per source 1..IRQ_NUM-1 with states IDLE, PEND, INFLIGHT.
REQ-010 SHALL move IDLE->PEND when request asserted (level high, or rising edge in edge mode); PEND->INFLIGHT on claim of that ID; INFLIGHT->IDLE on complete write of that ID.
REQ-011 SHALL, in level mode, move PEND->IDLE if irq_i deasserts before claim.
REQ-012 SHALL ignore requests while INFLIGHT; edges during INFLIGHT are dropped, level still high after complete re-pends next cycle.
REQ-013 SHALL set IP[i] = gateway i in PEND, visible one cycle after irq_i sample.
REQ-014 SHALL define eligible[i] = IP[i] & IE[i] & (PRIO[i] > THOLD); PRIO 0 never eligible.
REQ-015 SHALL select winner = eligible ID with highest PRIO, ties to lowest ID; 0 if none.
REQ-016 SHALL register ext_irq_o = (winner != 0), one cycle after IP/IE/PRIO/THOLD change.
REQ-017 SHALL, on reg_re_i at CLAIMCOMP, return winner and move that gateway to INFLIGHT on the same edge; winner 0 returns 0 with no state change.
REQ-018 SHALL, on reg_we_i at CLAIMCOMP, complete ID reg_wdata_i[4:0] only if that gateway is INFLIGHT; otherwise ignore (including ID 0 and ID >= IRQ_NUM).
REQ-019 SHALL give claim priority over a same-cycle new request of the same source; complete and re-request same cycle -> IDLE, re-evaluated next cycle.
REQ-020 SHALL accept simultaneous reg_we_i and reg_re_i as independent operations.
REQ-021 SHALL not clear INFLIGHT when IE bit is cleared; complete still accepted.

Reset
REQ-022 SHALL, on rst_i, clear PRIO, IE, THOLD, MODE, all gateways to IDLE, edge-detect history to 0, ext_irq_o to 0.
REQ-023 SHALL, on reset mid-claim, drop all INFLIGHT state; sources still high re-pend after reset release.

Configuration
REQ-024 SHALL use macro PLIC_EDGE_EN: defined -> MODE register present, MODE[i]=1 selects rising-edge trigger per source.
REQ-025 SHALL, without PLIC_EDGE_EN, treat all sources as level, MODE reads 0, no edge registers synthesised.

Structure
REQ-026 SHALL place register word indices, gateway state enum and max-source constant in package plic_pkg.
REQ-027 SHALL implement per-source gateway as sub-module plic_gateway, instantiated in a generate loop.

Verification
REQ-028 SHALL cover: PRIO[3]=5, IE=0x08, THOLD=2, irq_i[3]=1 -> ext_irq_o=1 within 2 cycles; claim reads 3; ext_irq_o=0 next cycle.
REQ-029 SHALL cover: PRIO[2]=4, PRIO[5]=4, PRIO[6]=7 all pending/enabled -> claims return 6, 2, 5 in order.
REQ-030 SHALL cover: PRIO[1]=2, THOLD=2 -> ext_irq_o stays 0; THOLD=1 -> ext_irq_o=1.
REQ-031 SHALL cover: source 4 claimed, irq_i[4] held high, complete 4 -> IP[4]=1 next cycle; complete 7 (not in flight) -> no change.
REQ-032 SHALL cover (PLIC_EDGE_EN): MODE[2]=1, 1-cycle pulse on irq_i[2] -> IP[2]=1 held; second pulse while INFLIGHT dropped.
REQ-033 SHALL cover: rst_i asserted with source 3 INFLIGHT -> all registers 0, ext_irq_o=0, claim reads 0.
